clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
- Time-of-day keeper that sits directly downstream of the clock divider.
- Consumes the divider's clk_1hz and clk_set square waves plus the raw hour/minute set buttons.
- Maintains BCD hours/minutes/seconds for the display and serialiser stages.
- Single system-clock domain (12.5 kHz clk); divider outputs are resynchronised and edge-detected internally.

Parameters:
- TWELVE_HOUR, 0: 0 = hours run 00..23; 1 = hours run 12,01..11 with AM/PM flag.
- SYNC_STAGES, 2: synchroniser depth on every asynchronous input (clk_1hz, clk_set, set_hours, set_minutes); legal values 2..3.

Ports:
- clk  input  1  system clock, 12.5 kHz; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- clk_1hz  input  1  1 Hz square wave from the divider; each rising edge is one second.
- clk_set  input  1  ~5 Hz square wave from the divider; each rising edge is one set-increment opportunity.
- set_hours  input  1  raw button level, active-high.
- set_minutes  input  1  raw button level, active-high.
- hours_tens  output  2  BCD.
- hours_ones  output  4  BCD.
- minutes_tens  output  3  BCD.
- minutes_ones  output  4  BCD.
- seconds_tens  output  3  BCD.
- seconds_ones  output  4  BCD.
- pm  output  1  PM flag; tied 0 when TWELVE_HOUR=0.
- time_changed  output  1  one-cycle strobe on any time update (tick or set).

Behaviour:
- Reset values:
  - TWELVE_HOUR=0: 00:00:00, pm=0.
  - TWELVE_HOUR=1: 12:00:00, pm=0.
  - time_changed=0; all synchroniser and edge flops 0; arm flag 0.
- Input conditioning:
  - Each input passes through a SYNC_STAGES flop chain, then a previous-value flop.
  - Rise event = synced & ~prev.
  - Latency: a time update is visible on the rising edge SYNC_STAGES+1 cycles after the first edge that samples the input high.
  - Arm flag sets SYNC_STAGES+1 cycles after reset release. Rise events are ignored while it is 0, so an input already high at reset release produces no tick.
- Tick (clk_1hz rise, no set button held):
  - seconds +1; 59 -> 00 carries to minutes.
  - minutes 59 -> 00 carries to hours.
  - TWELVE_HOUR=0: hours 23 -> 00.
  - TWELVE_HOUR=1: hours run 12 -> 01 .. 11 -> 12; pm toggles on the 11 -> 12 transition.
  - A full carry chain resolves in the same cycle; no intermediate values are ever visible.
- Set mode (either synced button high):
  - clk_1hz rise events are discarded; time is frozen.
  - On a clk_set rise with set_minutes held: minutes +1 mod 60, no carry into hours, seconds forced to 00.
  - On a clk_set rise with set_hours held: hours advance one step in the active sequence (pm toggles as for a tick); minutes and seconds unchanged.
  - Both buttons held: both increments apply on the same edge.
- Simultaneous clk_1hz and clk_set rises with a button held: the set action wins and the tick is lost.
- time_changed: asserted for exactly one cycle on each cycle in which any digit or pm changes.
- Reset asserted mid-operation: all outputs return to reset values asynchronously, with no glitch-free guarantee required.
- Invariant: BCD digits never hold values outside their legal range.

Decomposition:
- Shared package `clock_pkg` holds:
  - BCD limit constants (SEC_MAX=59, MIN_MAX=59, HR24_MAX=23, HR12_MIN=1, HR12_MAX=12).
  - Default SYNC_STAGES.
- One sub-module, `bcd_mod_counter`:
  - Two-digit BCD counter with parameters MAX and MIN.
  - Ports: inc, clear.
  - Outputs: tens, ones, and a carry pulse on wrap.
- The parent instantiates three bcd_mod_counter instances; hours uses MIN=1, MAX=12 in 12-hour mode.
- pm logic, synchronisers, edge detect, arm flag and set arbitration stay in the parent.

Test Plan:
- Reset release with clk_1hz already high, hold 4 cycles -> no tick; time stays 00:00:00; time_changed never asserts.
- Preload 23:59:58 via set, then two clk_1hz rises -> 23:59:59, then 00:00:00; time_changed pulses once per rise, SYNC_STAGES+1 cycles after each rise.
- set_minutes held with time 10:59:37, one clk_set rise -> 10:00:00 (minutes wrap with no hour carry; seconds cleared).
- TWELVE_HOUR=1 at 11:59:59 pm=0, one tick -> 12:00:00 pm=1; set_hours then steps 12 -> 01, with pm unchanged.
- set_hours held, clk_set and clk_1hz rise on the same cycle at 05:06:07 -> 06:06:07, no seconds change.
- reset pulsed mid-carry, on the cycle after a tick's rise is synchronised -> outputs immediately at reset values; no tick applied after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day keeper.
// BCD digit limits and synchroniser defaults.
package clock_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MIN = 1;
  localparam int HR12_MAX = 12;

  localparam int SYNC_STAGES_DEF = 2;

  function automatic int hr_max(input int twelve);
    return (twelve != 0) ? HR12_MAX : HR24_MAX;
  endfunction

  function automatic int hr_min(input int twelve);
    return (twelve != 0) ? HR12_MIN : 0;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN..MAX.
// carry pulses combinationally on the increment that wraps.
module bcd_mod_counter #(
  parameter int MAX = 59,
  parameter int MIN = 0,
  parameter int RST = 0,
  parameter int TW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clear,
  output logic [TW-1:0] tens,
  output logic [3:0]    ones,
  output logic          carry
);

  localparam logic [TW-1:0] MAX_T = TW'(MAX / 10);
  localparam logic [3:0]    MAX_O = 4'(MAX % 10);
  localparam logic [TW-1:0] MIN_T = TW'(MIN / 10);
  localparam logic [3:0]    MIN_O = 4'(MIN % 10);
  localparam logic [TW-1:0] RST_T = TW'(RST / 10);
  localparam logic [3:0]    RST_O = 4'(RST % 10);

  logic at_max;

  assign at_max = (tens == MAX_T) && (ones == MAX_O);
  assign carry  = inc && !clear && at_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens <= RST_T;
      ones <= RST_O;
    end else if (clear || carry) begin
      tens <= MIN_T;
      ones <= MIN_O;
    end else if (inc) begin
      if (ones == 4'd9) begin
        tens <= tens + 1'b1;
        ones <= '0;
      end else begin
        ones <= ones + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// BCD time-of-day keeper fed by the clock divider.
// Ticks on clk_1hz rises; set buttons step minutes/hours on clk_set rises.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int TWELVE_HOUR = 0,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1hz,
  input  logic       clk_set,
  input  logic       set_hours,
  input  logic       set_minutes,
  output logic [1:0] hours_tens,
  output logic [3:0] hours_ones,
  output logic [2:0] minutes_tens,
  output logic [3:0] minutes_ones,
  output logic [2:0] seconds_tens,
  output logic [3:0] seconds_ones,
  output logic       pm,
  output logic       time_changed
);

  localparam int HMAX = hr_max(TWELVE_HOUR);
  localparam int HMIN = hr_min(TWELVE_HOUR);
  localparam int HRST = (TWELVE_HOUR != 0) ? HR12_MAX : 0;

  logic [3:0] raw;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] synced;
  logic [1:0] prev_q;
  logic [1:0] rise;
  logic [1:0] rise_q;
  logic [1:0] arm_cnt;
  logic       arm_q;
  logic       pm_q;
  logic       tc_q;

  logic set_mode;
  logic tick;
  logic min_set;
  logic hr_set;
  logic sec_carry;
  logic min_carry;
  logic day_wrap;
  logic min_inc;
  logic hr_inc;
  logic hr_eleven;

  assign raw    = {set_minutes, set_hours, clk_set, clk_1hz};
  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced[1:0] & ~prev_q & {2{arm_q}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= synced[1:0];
      rise_q <= rise;
    end
  end

  // Hold off edge detection until the chains have flushed reset zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= '0;
      arm_q   <= 1'b0;
    end else if (!arm_q) begin
      if (arm_cnt == 2'(SYNC_STAGES)) arm_q <= 1'b1;
      else arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign set_mode = synced[2] | synced[3];
  assign tick     = rise_q[0] & ~set_mode;
  assign min_set  = rise_q[1] & synced[3];
  assign hr_set   = rise_q[1] & synced[2];
  assign min_inc  = min_set | sec_carry;
  assign hr_inc   = hr_set | (min_carry & tick);

  bcd_mod_counter #(
    .MAX(SEC_MAX), .MIN(0), .RST(0), .TW(3)
  ) u_sec (
    .clk(clk), .reset(reset),
    .inc(tick), .clear(min_set),
    .tens(seconds_tens), .ones(seconds_ones),
    .carry(sec_carry)
  );

  bcd_mod_counter #(
    .MAX(MIN_MAX), .MIN(0), .RST(0), .TW(3)
  ) u_min (
    .clk(clk), .reset(reset),
    .inc(min_inc), .clear(1'b0),
    .tens(minutes_tens), .ones(minutes_ones),
    .carry(min_carry)
  );

  bcd_mod_counter #(
    .MAX(HMAX), .MIN(HMIN), .RST(HRST), .TW(2)
  ) u_hr (
    .clk(clk), .reset(reset),
    .inc(hr_inc), .clear(1'b0),
    .tens(hours_tens), .ones(hours_ones),
    .carry(day_wrap)
  );

  assign hr_eleven = (hours_tens == 2'd1) && (hours_ones == 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pm_q <= 1'b0;
      tc_q <= 1'b0;
    end else begin
      if (hr_inc && hr_eleven) pm_q <= ~pm_q;
      tc_q <= tick | min_set | hr_set | day_wrap;
    end
  end

  assign pm           = (TWELVE_HOUR != 0) && pm_q;
  assign time_changed = tc_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: 24h and 12h instances share stimulus,
// checked against a seconds-of-day reference model.
module tb_clock_time_counter;

  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  logic clk_1hz;
  logic clk_set;
  logic set_hours;
  logic set_minutes;

  logic [1:0] ht_a, ht_b;
  logic [3:0] ho_a, ho_b;
  logic [2:0] mt_a, mt_b;
  logic [3:0] mo_a, mo_b;
  logic [2:0] st_a, st_b;
  logic [3:0] so_a, so_b;
  logic       pm_a, pm_b;
  logic       tc_a, tc_b;

  logic [20:0] got24, got12;

  int checks = 0;
  int errors = 0;
  int t = 0;

  always #5 clk = ~clk;

  clock_time_counter #(.TWELVE_HOUR(0), .SYNC_STAGES(S)) dut24 (
    .clk(clk), .reset(reset), .clk_1hz(clk_1hz), .clk_set(clk_set),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .hours_tens(ht_a), .hours_ones(ho_a),
    .minutes_tens(mt_a), .minutes_ones(mo_a),
    .seconds_tens(st_a), .seconds_ones(so_a),
    .pm(pm_a), .time_changed(tc_a)
  );

  clock_time_counter #(.TWELVE_HOUR(1), .SYNC_STAGES(S)) dut12 (
    .clk(clk), .reset(reset), .clk_1hz(clk_1hz), .clk_set(clk_set),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .hours_tens(ht_b), .hours_ones(ho_b),
    .minutes_tens(mt_b), .minutes_ones(mo_b),
    .seconds_tens(st_b), .seconds_ones(so_b),
    .pm(pm_b), .time_changed(tc_b)
  );

  assign got24 = {ht_a, ho_a, mt_a, mo_a, st_a, so_a, pm_a};
  assign got12 = {ht_b, ho_b, mt_b, mo_b, st_b, so_b, pm_b};

  function automatic logic [20:0] exp_time(input int tt, input bit twelve);
    int h, m, s, dh;
    bit p;
    h = tt / 3600;
    m = (tt / 60) % 60;
    s = tt % 60;
    dh = h;
    p = 1'b0;
    if (twelve) begin
      dh = (h % 12 == 0) ? 12 : h % 12;
      p = (h >= 12);
    end
    return {2'(dh / 10), 4'(dh % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), p};
  endfunction

  task automatic model_tick();
    t = (t + 1) % 86400;
  endtask

  task automatic model_set(input bit hb, input bit mb);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    if (mb) begin
      m = (m + 1) % 60;
      s = 0;
    end
    if (hb) h = (h + 1) % 24;
    t = h * 3600 + m * 60 + s;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; reports time_changed activity over 8 cycles.
  task automatic pulse(input bit p1, input bit ps,
                       output int n24, output int at24, output int n12);
    n24 = 0;
    at24 = 0;
    n12 = 0;
    if (p1) clk_1hz = 1'b1;
    if (ps) clk_set = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        clk_1hz = 1'b0;
        clk_set = 1'b0;
      end
      if (tc_a) begin
        n24++;
        if (at24 == 0) at24 = i;
      end
      if (tc_b) n12++;
    end
  endtask

  task automatic do_set(input bit hb, input bit mb, input int n);
    int a, b, c;
    set_hours = hb;
    set_minutes = mb;
    cyc(4);
    repeat (n) begin
      pulse(1'b0, 1'b1, a, b, c);
      model_set(hb, mb);
    end
    set_hours = 1'b0;
    set_minutes = 1'b0;
    cyc(4);
  endtask

  task automatic preload(input int h, input int m, input int s);
    int hs, ms, a, b, c;
    hs = (h - t / 3600 + 24) % 24;
    if (hs != 0) do_set(1'b1, 1'b0, hs);
    ms = (m - (t / 60) % 60 + 60) % 60;
    if (ms == 0) ms = 60;
    do_set(1'b0, 1'b1, ms);
    repeat (s) begin
      pulse(1'b1, 1'b0, a, b, c);
      model_tick();
    end
  endtask

  task automatic test_reset();
    int ntc;
    reset = 1'b1;
    clk_1hz = 1'b1;
    clk_set = 1'b0;
    set_hours = 1'b0;
    set_minutes = 1'b0;
    t = 0;
    cyc(3);
    checks++;
    if (got24 !== exp_time(0, 1'b0) || got12 !== exp_time(0, 1'b1)) begin
      errors++;
      $display("FAIL reset_vals: got %h/%h exp %h/%h",
               got24, got12, exp_time(0, 1'b0), exp_time(0, 1'b1));
    end
    reset = 1'b0;
    ntc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tc_a || tc_b) ntc++;
    end
    checks++;
    if (ntc !== 0) begin
      errors++;
      $display("FAIL release_tc: got %0d pulses exp 0", ntc);
    end
    checks++;
    if (got24 !== exp_time(0, 1'b0) || got12 !== exp_time(0, 1'b1)) begin
      errors++;
      $display("FAIL release_hold: got %h/%h exp %h/%h",
               got24, got12, exp_time(0, 1'b0), exp_time(0, 1'b1));
    end
    clk_1hz = 1'b0;
    cyc(6);
  endtask

  task automatic test_day_wrap();
    int n24, at24, n12;
    preload(23, 59, 58);
    checks++;
    if (got24 !== exp_time(t, 1'b0)) begin
      errors++;
      $display("FAIL preload_2359: got %h exp %h", got24, exp_time(t, 1'b0));
    end
    repeat (2) begin
      pulse(1'b1, 1'b0, n24, at24, n12);
      model_tick();
      checks++;
      if (got24 !== exp_time(t, 1'b0) || got12 !== exp_time(t, 1'b1)) begin
        errors++;
        $display("FAIL day_wrap: got %h/%h exp %h/%h",
                 got24, got12, exp_time(t, 1'b0), exp_time(t, 1'b1));
      end
      checks++;
      if (n24 !== 1 || at24 !== S + 2 || n12 !== 1) begin
        errors++;
        $display("FAIL tick_strobe: got n=%0d at=%0d n12=%0d exp 1/%0d/1",
                 n24, at24, n12, S + 2);
      end
    end
  endtask

  task automatic test_set_minutes();
    int n24, at24, n12;
    preload(10, 59, 37);
    set_minutes = 1'b1;
    cyc(4);
    pulse(1'b0, 1'b1, n24, at24, n12);
    model_set(1'b0, 1'b1);
    checks++;
    if (got24 !== exp_time(t, 1'b0) || got12 !== exp_time(t, 1'b1)) begin
      errors++;
      $display("FAIL set_min_wrap: got %h/%h exp %h/%h",
               got24, got12, exp_time(t, 1'b0), exp_time(t, 1'b1));
    end
    checks++;
    if (n24 !== 1 || at24 !== S + 2) begin
      errors++;
      $display("FAIL set_min_strobe: got n=%0d at=%0d exp 1/%0d",
               n24, at24, S + 2);
    end
    set_minutes = 1'b0;
    cyc(4);
  endtask

  task automatic test_twelve_hour();
    int n24, at24, n12;
    preload(11, 59, 59);
    checks++;
    if (got12 !== exp_time(t, 1'b1)) begin
      errors++;
      $display("FAIL preload_1159: got %h exp %h", got12, exp_time(t, 1'b1));
    end
    pulse(1'b1, 1'b0, n24, at24, n12);
    model_tick();
    checks++;
    if (got12 !== exp_time(t, 1'b1) || got24 !== exp_time(t, 1'b0)) begin
      errors++;
      $display("FAIL noon_pm: got %h/%h exp %h/%h",
               got12, got24, exp_time(t, 1'b1), exp_time(t, 1'b0));
    end
    set_hours = 1'b1;
    cyc(4);
    pulse(1'b0, 1'b1, n24, at24, n12);
    model_set(1'b1, 1'b0);
    checks++;
    if (got12 !== exp_time(t, 1'b1) || got24 !== exp_time(t, 1'b0)) begin
      errors++;
      $display("FAIL set_hr_12to1: got %h/%h exp %h/%h",
               got12, got24, exp_time(t, 1'b1), exp_time(t, 1'b0));
    end
    set_hours = 1'b0;
    cyc(4);
  endtask

  task automatic test_simultaneous();
    int n24, at24, n12;
    preload(5, 6, 7);
    set_hours = 1'b1;
    cyc(4);
    pulse(1'b1, 1'b1, n24, at24, n12);
    model_set(1'b1, 1'b0);
    checks++;
    if (got24 !== exp_time(t, 1'b0) || got12 !== exp_time(t, 1'b1)) begin
      errors++;
      $display("FAIL set_beats_tick: got %h/%h exp %h/%h",
               got24, got12, exp_time(t, 1'b0), exp_time(t, 1'b1));
    end
    checks++;
    if (n24 !== 1 || at24 !== S + 2) begin
      errors++;
      $display("FAIL simul_strobe: got n=%0d at=%0d exp 1/%0d",
               n24, at24, S + 2);
    end
    set_hours = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset_mid();
    int ntc;
    preload(23, 59, 59);
    clk_1hz = 1'b1;
    cyc(S + 1);
    reset = 1'b1;
    #1;
    t = 0;
    checks++;
    if (got24 !== exp_time(0, 1'b0) || got12 !== exp_time(0, 1'b1)) begin
      errors++;
      $display("FAIL async_reset: got %h/%h exp %h/%h",
               got24, got12, exp_time(0, 1'b0), exp_time(0, 1'b1));
    end
    cyc(2);
    reset = 1'b0;
    ntc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tc_a || tc_b) ntc++;
    end
    checks++;
    if (ntc !== 0 || got24 !== exp_time(0, 1'b0) ||
        got12 !== exp_time(0, 1'b1)) begin
      errors++;
      $display("FAIL post_reset: got %h/%h tc=%0d exp %h/%h tc=0",
               got24, got12, ntc, exp_time(0, 1'b0), exp_time(0, 1'b1));
    end
    clk_1hz = 1'b0;
    cyc(6);
  endtask

  task automatic test_random();
    int op, n24, at24, n12, expn;
    bit hb, mb, p1, ps;
    preload($urandom_range(0, 23), $urandom_range(0, 59),
            $urandom_range(0, 59));
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 5);
      cyc($urandom_range(0, 3));
      hb = (op == 3) || (op == 4);
      mb = (op == 2) || (op == 4) || (op == 5);
      p1 = (op <= 1) || (op == 5) || ($urandom_range(0, 1) == 1 && op >= 2);
      ps = (op >= 2) && (op <= 4);
      set_hours = hb;
      set_minutes = mb;
      if (hb || mb) cyc(4);
      pulse(p1, ps, n24, at24, n12);
      expn = 0;
      if (hb || mb) begin
        if (ps) begin
          model_set(hb, mb);
          expn = 1;
        end
      end else if (p1) begin
        model_tick();
        expn = 1;
      end
      checks++;
      if (got24 !== exp_time(t, 1'b0) || got12 !== exp_time(t, 1'b1)) begin
        errors++;
        $display("FAIL random_op%0d: got %h/%h exp %h/%h", op,
                 got24, got12, exp_time(t, 1'b0), exp_time(t, 1'b1));
      end
      checks++;
      if (n24 !== expn || n12 !== expn) begin
        errors++;
        $display("FAIL random_tc%0d: got %0d/%0d exp %0d",
                 op, n24, n12, expn);
      end
      set_hours = 1'b0;
      set_minutes = 1'b0;
      cyc(4);
    end
  endtask

  initial begin
    test_reset();
    test_day_wrap();
    test_set_minutes();
    test_twelve_hour();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
